// File: rtl/cpu_axi_bridge.sv
// Bridges the core's SRAM-style fetch and data ports onto a single-beat AXI master.
// Only one transaction is in flight at a time, and data requests take priority over fetch.
module cpu_axi_bridge (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_sram_en,
    input  logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_rdata,
    output logic        inst_stall,

    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_stall,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,

    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,

    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,

    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,

    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        owner_data_q;
    logic        aw_done;
    logic        w_done;
    logic        inst_ok;
    logic        data_ok;
    logic [31:0] inst_rdata_q;
    logic [31:0] data_rdata_q;

    logic        data_go;
    logic        inst_go;
    logic        aw_fire;
    logic        w_fire;
    logic        aw_all;
    logic        w_all;

    // A requester whose ok pulse is high is retiring this cycle and must not restart.
    assign data_go = data_sram_en & ~data_ok;
    assign inst_go = inst_sram_en & ~inst_ok;

    assign aw_fire = (state == WR_REQ) & ~aw_done & awready;
    assign w_fire  = (state == WR_REQ) & ~w_done & wready;
    assign aw_all  = aw_done | aw_fire;
    assign w_all   = w_done | w_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        arvalid    = 1'b0;
        rready     = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        case (state)
            IDLE: begin
                if (data_go) begin
                    next_state = (|data_sram_wen) ? WR_REQ : RD_ADDR;
                end else if (inst_go) begin
                    next_state = RD_ADDR;
                end
            end
            RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) next_state = RD_DATA;
            end
            RD_DATA: begin
                rready = 1'b1;
                if (rvalid) next_state = IDLE;
            end
            WR_REQ: begin
                awvalid = ~aw_done;
                wvalid  = ~w_done;
                if (aw_all && w_all) next_state = WR_RESP;
            end
            WR_RESP: begin
                bready = 1'b1;
                if (bvalid) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            owner_data_q <= 1'b0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            inst_ok      <= 1'b0;
            data_ok      <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            inst_ok <= 1'b0;
            data_ok <= 1'b0;

            if (state == IDLE && next_state != IDLE) begin
                owner_data_q <= data_go;
                addr_q       <= data_go ? data_sram_addr : inst_sram_addr;
                wdata_q      <= data_sram_wdata;
                wstrb_q      <= data_go ? data_sram_wen : '0;
            end

            if (state == WR_REQ) begin
                if (aw_all && w_all) begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end else begin
                    if (aw_fire) aw_done <= 1'b1;
                    if (w_fire)  w_done  <= 1'b1;
                end
            end

            if (state == RD_DATA && rvalid) begin
                if (owner_data_q) begin
                    data_rdata_q <= rdata;
                    data_ok      <= 1'b1;
                end else begin
                    inst_rdata_q <= rdata;
                    inst_ok      <= 1'b1;
                end
            end

            if (state == WR_RESP && bvalid) begin
                data_ok <= 1'b1;
            end
        end
    end

    assign arid            = {3'b000, owner_data_q};
    assign araddr          = addr_q;
    assign arsize          = 3'd2;
    assign awaddr          = addr_q;
    assign awsize          = 3'd2;
    assign wdata           = wdata_q;
    assign wstrb           = wstrb_q;
    assign inst_sram_rdata = inst_rdata_q;
    assign data_sram_rdata = data_rdata_q;
    assign inst_stall      = inst_sram_en & ~inst_ok;
    assign data_stall      = data_sram_en & ~data_ok;

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge: the bench plays the AXI slave cycle by cycle.
// Inputs are driven 1 time unit after posedge; outputs are checked 1 unit later.
module tb_cpu_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic        inst_stall;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        data_stall;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    always #5 clk = ~clk;

    cpu_axi_bridge dut (
        .clk             (clk),
        .rst             (rst),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata),
        .inst_stall      (inst_stall),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .data_stall      (data_stall),
        .arid            (arid),
        .araddr          (araddr),
        .arsize          (arsize),
        .arvalid         (arvalid),
        .arready         (arready),
        .rdata           (rdata),
        .rvalid          (rvalid),
        .rready          (rready),
        .awaddr          (awaddr),
        .awsize          (awsize),
        .awvalid         (awvalid),
        .awready         (awready),
        .wdata           (wdata),
        .wstrb           (wstrb),
        .wvalid          (wvalid),
        .wready          (wready),
        .bvalid          (bvalid),
        .bready          (bready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        inst_sram_en = 1'b0; inst_sram_addr = '0;
        data_sram_en = 1'b0; data_sram_wen = '0; data_sram_addr = '0; data_sram_wdata = '0;
        arready = 1'b0; rdata = '0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        settle();
        check("rst_arvalid", {31'b0, arvalid}, 32'd0);
        check("rst_rready",  {31'b0, rready},  32'd0);
        check("rst_awvalid", {31'b0, awvalid}, 32'd0);
        check("rst_wvalid",  {31'b0, wvalid},  32'd0);
        check("rst_bready",  {31'b0, bready},  32'd0);
        check("rst_irdata",  inst_sram_rdata,  32'h0);
        check("rst_drdata",  data_sram_rdata,  32'h0);
        check("rst_istall",  {31'b0, inst_stall}, 32'd0);
        tick();

        // Zero-wait fetch
        inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC00000; arready = 1'b1;
        settle();
        check("f_T_stall", {31'b0, inst_stall}, 32'd1);
        check("f_T_arv",   {31'b0, arvalid},    32'd0);
        tick();
        settle();
        check("f_T1_arv",   {31'b0, arvalid}, 32'd1);
        check("f_T1_araddr", araddr, 32'hBFC00000);
        check("f_T1_arid",  {28'b0, arid},    32'd0);
        check("f_T1_arsize", {29'b0, arsize}, 32'd2);
        check("f_T1_stall", {31'b0, inst_stall}, 32'd1);
        tick();
        rvalid = 1'b1; rdata = 32'h3C1D8000;
        settle();
        check("f_T2_rready", {31'b0, rready},  32'd1);
        check("f_T2_arv",    {31'b0, arvalid}, 32'd0);
        check("f_T2_stall",  {31'b0, inst_stall}, 32'd1);
        tick();
        rvalid = 1'b0; rdata = '0;
        settle();
        check("f_T3_stall", {31'b0, inst_stall}, 32'd0);
        check("f_T3_rdata", inst_sram_rdata, 32'h3C1D8000);
        tick();
        inst_sram_en = 1'b0;
        settle();
        check("f_T4_noreissue", {31'b0, arvalid}, 32'd0);
        check("f_T4_rdata_hold", inst_sram_rdata, 32'h3C1D8000);
        tick();

        // Simultaneous fetch and load: data wins, fetch follows data_ok
        inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC00004;
        data_sram_en = 1'b1; data_sram_wen = 4'b0000; data_sram_addr = 32'h80001000;
        tick();
        settle();
        check("p_arid_data", {28'b0, arid}, 32'd1);
        check("p_araddr",    araddr, 32'h80001000);
        check("p_arv",       {31'b0, arvalid}, 32'd1);
        tick();
        rvalid = 1'b1; rdata = 32'hDEADBEEF;
        settle();
        check("p_rready", {31'b0, rready}, 32'd1);
        tick();
        rvalid = 1'b0;
        settle();
        check("p_dstall", {31'b0, data_stall}, 32'd0);
        check("p_drdata", data_sram_rdata, 32'hDEADBEEF);
        check("p_istall", {31'b0, inst_stall}, 32'd1);
        check("p_arv_idle", {31'b0, arvalid}, 32'd0);
        tick();
        data_sram_en = 1'b0;
        settle();
        check("p_fetch_arv",  {31'b0, arvalid}, 32'd1);
        check("p_fetch_arid", {28'b0, arid}, 32'd0);
        check("p_fetch_addr", araddr, 32'hBFC00004);
        tick();
        rvalid = 1'b1; rdata = 32'h11112222;
        tick();
        rvalid = 1'b0;
        settle();
        check("p_istall_done", {31'b0, inst_stall}, 32'd0);
        check("p_irdata", inst_sram_rdata, 32'h11112222);
        check("p_drdata_hold", data_sram_rdata, 32'hDEADBEEF);
        tick();
        inst_sram_en = 1'b0; arready = 1'b0;
        tick();

        // Store, W accepted two cycles before AW
        data_sram_en = 1'b1; data_sram_wen = 4'b0011;
        data_sram_addr = 32'h80002000; data_sram_wdata = 32'h12345678;
        tick();
        wready = 1'b1;
        settle();
        check("w_awv",    {31'b0, awvalid}, 32'd1);
        check("w_wv",     {31'b0, wvalid},  32'd1);
        check("w_wstrb",  {28'b0, wstrb},   32'h3);
        check("w_wdata",  wdata,  32'h12345678);
        check("w_awaddr", awaddr, 32'h80002000);
        check("w_awsize", {29'b0, awsize}, 32'd2);
        tick();
        wready = 1'b0;
        settle();
        check("w_wv_drop",  {31'b0, wvalid},  32'd0);
        check("w_awv_hold", {31'b0, awvalid}, 32'd1);
        check("w_bready_0", {31'b0, bready},  32'd0);
        tick();
        awready = 1'b1;
        settle();
        check("w_awv_hold2", {31'b0, awvalid}, 32'd1);
        check("w_wv_low2",   {31'b0, wvalid},  32'd0);
        tick();
        awready = 1'b0; bvalid = 1'b1;
        settle();
        check("w_awv_drop", {31'b0, awvalid}, 32'd0);
        check("w_bready",   {31'b0, bready},  32'd1);
        check("w_dstall",   {31'b0, data_stall}, 32'd1);
        tick();
        bvalid = 1'b0;
        settle();
        check("w_dstall_done", {31'b0, data_stall}, 32'd0);
        check("w_bready_idle", {31'b0, bready}, 32'd0);
        tick();
        data_sram_en = 1'b0; data_sram_wen = '0;
        settle();
        check("w_no_restart_aw", {31'b0, awvalid}, 32'd0);
        check("w_no_restart_w",  {31'b0, wvalid},  32'd0);
        tick();

        // Load with arready held off while core inputs toggle
        data_sram_en = 1'b1; data_sram_wen = 4'b0000; data_sram_addr = 32'h80003000;
        tick();
        for (int unsigned i = 0; i < 5; i++) begin
            data_sram_addr = 32'hA5A50000 + i;
            data_sram_wen  = 4'(i + 1);
            inst_sram_en   = i[0];
            inst_sram_addr = 32'h00000100 * i;
            settle();
            check("s_arv",    {31'b0, arvalid}, 32'd1);
            check("s_araddr", araddr, 32'h80003000);
            check("s_arid",   {28'b0, arid}, 32'd1);
            tick();
        end
        inst_sram_en = 1'b0; data_sram_wen = 4'b0000; data_sram_addr = 32'h80003000;
        arready = 1'b1;
        settle();
        check("s_araddr_hs", araddr, 32'h80003000);
        tick();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'hCAFEF00D;
        tick();
        rvalid = 1'b0;
        settle();
        check("s_drdata", data_sram_rdata, 32'hCAFEF00D);
        check("s_dstall", {31'b0, data_stall}, 32'd0);
        tick();
        data_sram_en = 1'b0;
        tick();

        // Reset while in RD_DATA, with rvalid arriving in the same cycle
        inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC00008; arready = 1'b1;
        tick();
        tick();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h55AA55AA; rst = 1'b1;
        settle();
        check("r_rready_pre", {31'b0, rready}, 32'd1);
        tick();
        rvalid = 1'b0;
        settle();
        check("r_arv",    {31'b0, arvalid}, 32'd0);
        check("r_rready", {31'b0, rready},  32'd0);
        check("r_istall", {31'b0, inst_stall}, 32'd1);
        check("r_irdata", inst_sram_rdata, 32'h0);
        check("r_drdata", data_sram_rdata, 32'h0);
        rst = 1'b0; inst_sram_en = 1'b0;
        tick();
        settle();
        check("r_idle_arv", {31'b0, arvalid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
